// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Core-wide widths, ARF recovery state encoding and beat count.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int XLEN            = 32;
    localparam int ARCH_REGS       = 32;
    localparam int ARF_RECOV_BEATS = ARCH_REGS / 2;

    typedef enum logic [1:0] {
        RS_IDLE  = 2'd0,
        RS_WALK  = 2'd1,
        RS_DRAIN = 2'd2
    } arf_recov_state_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/arf_recovery_seq.sv
`default_nettype none
// ============================================================================
// Module      : arf_recovery_seq
// Description : Walks the ARF two registers per beat on recovery, streaming
//               them over valid/ready; lends read port 0 to debug while idle.
// Revision    : 1.0 - initial release
// ============================================================================
module arf_recovery_seq #(
    parameter int XLEN      = core_pkg::XLEN,
    parameter int ARCH_REGS = core_pkg::ARCH_REGS,
    localparam int IDX_W    = $clog2(ARCH_REGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recover_start,
    output logic             recover_busy,
    output logic             recover_done,
    output logic             commit_stall,
    input  logic             dbg_req_valid,
    output logic             dbg_req_ready,
    input  logic [IDX_W-1:0] dbg_addr,
    output logic             dbg_rsp_valid,
    output logic [XLEN-1:0]  dbg_rsp_data,
    output logic [IDX_W-1:0] arf_raddr0,
    input  logic [XLEN-1:0]  arf_rdata0,
    output logic [IDX_W-1:0] arf_raddr1,
    input  logic [XLEN-1:0]  arf_rdata1,
    output logic             rst_valid,
    input  logic             rst_ready,
    output logic [IDX_W-1:0] rst_idx,
    output logic [XLEN-1:0]  rst_data0,
    output logic [XLEN-1:0]  rst_data1
);

    import core_pkg::*;

    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(ARCH_REGS - 2);
    localparam logic [IDX_W-1:0] c_step     = IDX_W'(2);

    arf_recov_state_t r_state;
    arf_recov_state_t w_state_nxt;

    logic [IDX_W-1:0] r_idx;
    logic             r_rst_valid;
    logic [IDX_W-1:0] r_rst_idx;
    logic [XLEN-1:0]  r_rst_data0;
    logic [XLEN-1:0]  r_rst_data1;
    logic             r_dbg_rsp_valid;
    logic [XLEN-1:0]  r_dbg_rsp_data;

    logic             w_load;
    logic             w_dbg_fire;
    logic             w_done;
    logic             w_dbg_ready;
    logic [IDX_W-1:0] w_raddr0;
    logic [IDX_W-1:0] w_raddr1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= RS_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_dbg_fire  = 1'b0;
        w_done      = 1'b0;
        w_dbg_ready = 1'b0;
        w_raddr0    = '0;
        w_raddr1    = '0;
        case (r_state)
            RS_IDLE: begin
                w_raddr0    = dbg_addr;
                w_dbg_ready = !recover_start;
                w_dbg_fire  = dbg_req_valid && !recover_start;
                if (recover_start) begin
                    w_state_nxt = RS_WALK;
                end
            end
            RS_WALK: begin
                w_raddr0 = r_idx;
                w_raddr1 = r_idx + 1'b1;
                // The output stage refills whenever it is empty or being drained.
                w_load   = !r_rst_valid || rst_ready;
                if (w_load && (r_idx == c_last_idx)) begin
                    w_state_nxt = RS_DRAIN;
                end
            end
            RS_DRAIN: begin
                if (r_rst_valid && rst_ready) begin
                    w_done      = 1'b1;
                    w_state_nxt = RS_IDLE;
                end
            end
            default: begin
                w_state_nxt = RS_IDLE;
            end
        endcase
    end

    // The index restarts at 0 after the last pair so it never wraps past the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (w_load) begin
            r_idx <= (r_idx == c_last_idx) ? '0 : r_idx + c_step;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rst_valid <= 1'b0;
            r_rst_idx   <= '0;
            r_rst_data0 <= '0;
            r_rst_data1 <= '0;
        end else if (w_load) begin
            r_rst_valid <= 1'b1;
            r_rst_idx   <= r_idx;
            r_rst_data0 <= arf_rdata0;
            r_rst_data1 <= arf_rdata1;
        end else if (w_done) begin
            r_rst_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dbg_rsp_valid <= 1'b0;
            r_dbg_rsp_data  <= '0;
        end else begin
            r_dbg_rsp_valid <= w_dbg_fire;
            if (w_dbg_fire) begin
                r_dbg_rsp_data <= arf_rdata0;
            end
        end
    end

    assign recover_busy  = (r_state != RS_IDLE);
    assign commit_stall  = (r_state != RS_IDLE);
    assign recover_done  = w_done;
    assign dbg_req_ready = w_dbg_ready;
    assign dbg_rsp_valid = r_dbg_rsp_valid;
    assign dbg_rsp_data  = r_dbg_rsp_data;
    assign arf_raddr0    = w_raddr0;
    assign arf_raddr1    = w_raddr1;
    assign rst_valid     = r_rst_valid;
    assign rst_idx       = r_rst_idx;
    assign rst_data0     = r_rst_data0;
    assign rst_data1     = r_rst_data1;

endmodule : arf_recovery_seq
`default_nettype wire

// File: tb/tb_arf_recovery_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_arf_recovery_seq
// Description : Randomized self-checking bench for arf_recovery_seq against a
//               register-array reference of the walk and debug behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arf_recovery_seq;

    import core_pkg::*;

    localparam int XL    = XLEN;
    localparam int NR    = ARCH_REGS;
    localparam int IW    = $clog2(NR);
    localparam int BEATS = ARF_RECOV_BEATS;

    logic          clk;
    logic          reset;
    logic          recover_start;
    logic          recover_busy;
    logic          recover_done;
    logic          commit_stall;
    logic          dbg_req_valid;
    logic          dbg_req_ready;
    logic [IW-1:0] dbg_addr;
    logic          dbg_rsp_valid;
    logic [XL-1:0] dbg_rsp_data;
    logic [IW-1:0] arf_raddr0;
    logic [XL-1:0] arf_rdata0;
    logic [IW-1:0] arf_raddr1;
    logic [XL-1:0] arf_rdata1;
    logic          rst_valid;
    logic          rst_ready;
    logic [IW-1:0] rst_idx;
    logic [XL-1:0] rst_data0;
    logic [XL-1:0] rst_data1;

    logic [XL-1:0] arf_mem [NR];

    int n_checks = 0;
    int n_errors = 0;

    arf_recovery_seq #(
        .XLEN      (XL),
        .ARCH_REGS (NR)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .recover_start (recover_start),
        .recover_busy  (recover_busy),
        .recover_done  (recover_done),
        .commit_stall  (commit_stall),
        .dbg_req_valid (dbg_req_valid),
        .dbg_req_ready (dbg_req_ready),
        .dbg_addr      (dbg_addr),
        .dbg_rsp_valid (dbg_rsp_valid),
        .dbg_rsp_data  (dbg_rsp_data),
        .arf_raddr0    (arf_raddr0),
        .arf_rdata0    (arf_rdata0),
        .arf_raddr1    (arf_raddr1),
        .arf_rdata1    (arf_rdata1),
        .rst_valid     (rst_valid),
        .rst_ready     (rst_ready),
        .rst_idx       (rst_idx),
        .rst_data0     (rst_data0),
        .rst_data1     (rst_data1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural register file: combinational reads, x0 hardwired to zero.
    always_comb begin
        arf_rdata0 = (arf_raddr0 == '0) ? '0 : arf_mem[arf_raddr0];
        arf_rdata1 = (arf_raddr1 == '0) ? '0 : arf_mem[arf_raddr1];
    end

    function automatic logic [XL-1:0] reg_val(input int i);
        return (i == 0) ? '0 : arf_mem[i];
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // mode 0: ready held high, 1: ready alternating, 2: ready random.
    task automatic do_walk(input int mode, input bit repulse, input bit collide, input int abort_after);
        int            nbeats    = 0;
        int            cyc       = 0;
        int            first_hs  = -1;
        int            last_hs   = -1;
        bit            done_seen = 1'b0;
        bit            prev_stall = 1'b0;
        bit            tog       = 1'b0;
        logic [IW-1:0] p_idx     = '0;
        logic [XL-1:0] p_d0      = '0;
        logic [XL-1:0] p_d1      = '0;

        @(posedge clk); #1;
        recover_start = 1'b1;
        dbg_req_valid = collide;
        dbg_addr      = IW'($urandom_range(0, NR - 1));
        rst_ready     = 1'b1;
        @(negedge clk);
        check("busy_start_cycle", recover_busy, 0);
        if (collide) check("dbg_ready_collide", dbg_req_ready, 0);

        while (!done_seen && cyc < 400) begin
            @(posedge clk); #1;
            recover_start = repulse ? 1'($urandom_range(0, 1)) : 1'b0;
            dbg_req_valid = collide ? 1'($urandom_range(0, 1)) : 1'b0;
            case (mode)
                0:       rst_ready = 1'b1;
                1:       begin tog = ~tog; rst_ready = tog; end
                default: rst_ready = 1'($urandom_range(0, 1));
            endcase
            cyc++;
            @(negedge clk);
            if (cyc == 1 && collide) check("dbg_rsp_collide", dbg_rsp_valid, 0);
            check("busy", recover_busy, 1);
            check("stall", commit_stall, 1);
            check("dbg_ready_busy", dbg_req_ready, 0);
            if (prev_stall) begin
                check("hold_valid", rst_valid, 1);
                check("hold_idx", rst_idx, p_idx);
                check("hold_d0", rst_data0, p_d0);
                check("hold_d1", rst_data1, p_d1);
            end
            if (rst_valid && rst_ready) begin
                check("beat_idx", rst_idx, 2 * nbeats);
                check("beat_d0", rst_data0, reg_val(2 * nbeats));
                check("beat_d1", rst_data1, reg_val(2 * nbeats + 1));
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                nbeats++;
            end
            prev_stall = rst_valid && !rst_ready;
            p_idx = rst_idx;
            p_d0  = rst_data0;
            p_d1  = rst_data1;
            if (recover_done) begin
                check("done_after_last_beat", nbeats, BEATS);
                done_seen = 1'b1;
            end
            if (abort_after > 0 && nbeats == abort_after) begin
                #1 reset = 1'b1;
                #1;
                check("abort_valid", rst_valid, 0);
                check("abort_idx", rst_idx, 0);
                check("abort_d0", rst_data0, 0);
                check("abort_busy", recover_busy, 0);
                check("abort_stall", commit_stall, 0);
                check("abort_done", recover_done, 0);
                check("abort_dbg_rsp", dbg_rsp_valid, 0);
                recover_start = 1'b0;
                dbg_req_valid = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("abort_no_done", recover_done, 0);
                    check("abort_hold_valid", rst_valid, 0);
                end
                reset = 1'b0;
                return;
            end
        end

        check("done_seen", done_seen, 1);
        check("beat_count", nbeats, BEATS);
        if (mode == 0) begin
            check("first_beat_cycle", first_hs, 2);
            check("beats_consecutive", last_hs - first_hs, BEATS - 1);
        end

        @(posedge clk); #1;
        recover_start = 1'b0;
        dbg_req_valid = 1'b0;
        rst_ready     = 1'b1;
        @(negedge clk);
        check("idle_busy", recover_busy, 0);
        check("idle_stall", commit_stall, 0);
        check("idle_done", recover_done, 0);
        check("idle_valid", rst_valid, 0);
    endtask

    task automatic dbg_read(input int addr);
        @(posedge clk); #1;
        dbg_req_valid = 1'b1;
        dbg_addr      = IW'(addr);
        @(negedge clk);
        check("dbg_ready_idle", dbg_req_ready, 1);
        check("dbg_raddr0", arf_raddr0, addr);
        @(posedge clk); #1;
        dbg_req_valid = 1'b0;
        @(negedge clk);
        check("dbg_rsp_valid", dbg_rsp_valid, 1);
        check("dbg_rsp_data", dbg_rsp_data, reg_val(addr));
        @(posedge clk); #1;
        @(negedge clk);
        check("dbg_rsp_pulse", dbg_rsp_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b1;
        recover_start = 1'b0;
        dbg_req_valid = 1'b0;
        dbg_addr      = '0;
        rst_ready     = 1'b0;
        for (int i = 0; i < NR; i++) arf_mem[i] = XL'(i * 32'h11);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", rst_valid, 0);
        check("rst_idx", rst_idx, 0);
        check("rst_data0", rst_data0, 0);
        check("rst_data1", rst_data1, 0);
        check("rst_busy", recover_busy, 0);
        check("rst_stall", commit_stall, 0);
        check("rst_done", recover_done, 0);
        check("rst_dbg_rsp", dbg_rsp_valid, 0);
        reset = 1'b0;

        do_walk(0, 1'b0, 1'b0, 0);
        do_walk(1, 1'b0, 1'b0, 0);
        dbg_read(7);
        dbg_read(0);
        do_walk(0, 1'b0, 1'b1, 0);
        do_walk(2, 1'b0, 1'b0, 5);
        do_walk(0, 1'b0, 1'b0, 0);
        do_walk(2, 1'b1, 1'b0, 0);
        do_walk(0, 1'b1, 1'b0, 0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NR; i++) arf_mem[i] = XL'($urandom);
            dbg_read($urandom_range(0, NR - 1));
            do_walk(r % 3, 1'(r & 1), 1'((r >> 1) & 1), 0);
            dbg_read($urandom_range(0, NR - 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_arf_recovery_seq
`default_nettype wire
